// File: rtl/s4_bit_adder_if.sv
// Operand/result bundle for the registered 4-bit adder leaf cell.
// master drives operands, slave returns the registered result.
interface s4_bit_adder_if;
  logic [3:0] a;
  logic [3:0] b;
  logic       c_in;
  logic       in_valid;
  logic [3:0] sum;
  logic       carry_out;
  logic       out_valid;

  modport master (
    output a, b, c_in, in_valid,
    input  sum, carry_out, out_valid
  );

  modport slave (
    input  a, b, c_in, in_valid,
    output sum, carry_out, out_valid
  );
endinterface

// File: rtl/s4_bit_adder.sv
// Registered 4-bit ripple-carry adder: {carry_out,sum} = a + b + c_in.
// Four explicit full-adder cells feed the output registers; latency 1.
module s4_bit_adder (
  input  logic               clk,
  input  logic               rst,
  s4_bit_adder_if.slave      bus
);

  logic [4:0] w_c;
  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [3:0] w_s;

  logic [3:0] r_sum;
  logic       r_carry;
  logic       r_valid;

  assign w_c[0] = bus.c_in;

  // c_{i+1} = g_i | c_i & p_i, ripple from bit 0 to bit 3
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign w_p[i]   = bus.a[i] ^ bus.b[i];
    assign w_g[i]   = bus.a[i] & bus.b[i];
    assign w_s[i]   = w_p[i] ^ w_c[i];
    assign w_c[i+1] = w_g[i] | (w_c[i] & w_p[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum   <= 4'b0000;
      r_carry <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_sum   <= w_s;
        r_carry <= w_c[4];
      end
    end
  end

  assign bus.sum       = r_sum;
  assign bus.carry_out = r_carry;
  assign bus.out_valid = r_valid;

endmodule

// File: tb/tb_s4_bit_adder.sv
// Directed and exhaustive checks for the registered 4-bit adder.
// Expected results come from hand values and a behavioural a+b+c_in.
module tb_s4_bit_adder;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  s4_bit_adder_if bus ();

  s4_bit_adder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(
    input logic [3:0] a,
    input logic [3:0] b,
    input logic       ci,
    input logic       v
  );
    @(negedge clk);
    bus.a        = a;
    bus.b        = b;
    bus.c_in     = ci;
    bus.in_valid = v;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] res();
    return {26'd0, bus.out_valid, bus.carry_out, bus.sum};
  endfunction

  initial begin
    n_chk        = 0;
    n_fail       = 0;
    rst          = 1'b1;
    bus.a        = 4'hF;
    bus.b        = 4'hF;
    bus.c_in     = 1'b1;
    bus.in_valid = 1'b1;

    // in_valid high while in reset must be ignored
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hold", res(), 32'h00);

    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;

    drive(4'b1111, 4'b1100, 1'b1, 1'b1);
    chk("f_c_1", res(), {26'd0, 1'b1, 5'd28});
    drive(4'b0101, 4'b0100, 1'b0, 1'b1);
    chk("5_4_0", res(), {26'd0, 1'b1, 5'd9});
    drive(4'b1011, 4'b1001, 1'b0, 1'b1);
    chk("b_9_0", res(), {26'd0, 1'b1, 5'd20});
    drive(4'b1010, 4'b0101, 1'b1, 1'b1);
    chk("ripple", res(), {26'd0, 1'b1, 5'd16});

    drive(4'b0011, 4'b0001, 1'b0, 1'b0);
    chk("hold_1", res(), {26'd0, 1'b0, 5'd16});
    drive(4'b0110, 4'b0111, 1'b1, 1'b0);
    chk("hold_2", res(), {26'd0, 1'b0, 5'd16});

    // mid-stream asynchronous reset between edges
    drive(4'b1000, 4'b1000, 1'b1, 1'b1);
    chk("pre_rst", res(), {26'd0, 1'b1, 5'd17});
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", res(), 32'h00);
    @(posedge clk);
    #1;
    chk("rst_ign_v", res(), 32'h00);
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("no_replay", res(), 32'h00);

    drive(4'b0001, 4'b0010, 1'b0, 1'b1);
    chk("post_rst", res(), {26'd0, 1'b1, 5'd3});

    for (int i = 0; i < 512; i++) begin
      logic [8:0]  v;
      logic [31:0] e;
      v = i[8:0];
      drive(v[7:4], v[3:0], v[8], 1'b1);
      e = {26'd0, 1'b1, 5'(v[7:4] + v[3:0] + v[8])};
      chk($sformatf("exh_%0d", i), res(), e);
    end

    drive(4'b0000, 4'b0000, 1'b0, 1'b0);
    chk("exh_end", res(), {26'd0, 1'b0, 5'd31});

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/s4_bit_adder.md
# s4_bit_adder

Registered 4-bit binary adder with carry-in and carry-out. It computes a + b + c_in through a ripple chain of four full-adder cells and registers the 5-bit result on the clock. It is the basic arithmetic leaf cell for the wider adder blocks in the datapath, for example cascading via carry_out → c_in.

## Interface
- No parameters. Width is fixed at 4 bits.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- a  input  4  addend A, unsigned.
- b  input  4  addend B, unsigned.
- c_in  input  1  carry into bit 0.
- in_valid  input  1  qualifies a/b/c_in for capture on this edge.
- sum  output  4  registered sum bits [3:0].
- carry_out  output  1  registered carry out of bit 3.
- out_valid  output  1  high for exactly the cycle following each accepted operand set.

## Operation
- Combinational core: four full-adder cells chained bit 0 → bit 3.
  - Each cell computes s_i = a_i ^ b_i ^ c_i and c_{i+1} = a_i·b_i | c_i·(a_i ^ b_i).
  - c_0 = c_in.
  - The core uses explicit gate equations. It does not use a behavioural "+".
- Result = {c_4, s[3:0]}, which equals a + b + c_in exactly. The range is 0..31, so there is no truncation. carry_out is the 5th bit.
- Unsigned semantics only. No signed-overflow output is provided.
- Capture: on a rising clk with in_valid=1:
  - sum ← s[3:0]
  - carry_out ← c_4
  - out_valid ← 1
- On a rising clk with in_valid=0:
  - sum and carry_out hold their previous values.
  - out_valid ← 0.
- No backpressure. Every valid input is accepted, so back-to-back valid inputs produce back-to-back results.
- Inputs are sampled only at the clock edge. Changes between edges have no effect on the outputs.

## Timing
- Latency: 1 cycle. Operands presented with in_valid at edge N appear on sum/carry_out/out_valid immediately after edge N. They stay stable until the next accepted edge.
- Throughput: one addition per cycle.
- Reset (rst=1, asynchronous): sum=4'b0000, carry_out=0, out_valid=0 immediately, independent of clk.
- While rst is high, the outputs stay at their reset values and in_valid is ignored.
- Deassertion: the first capture happens on the first rising edge where rst=0 and in_valid=1.
- Reset mid-stream: a result already registered is lost, and out_valid drops at once. Nothing is replayed after reset.
- Critical path: c_in → c_4, four carry stages, ending at the output registers. No path runs combinationally from input to output.

## Test plan
- Reset: assert rst asynchronously between edges → sum=0, carry_out=0, out_valid=0 with no clock edge; in_valid=1 during reset is ignored.
- a=4'b1111, b=4'b1100, c_in=1, in_valid=1 → after the edge sum=4'b1100 (12), carry_out=1 (total 28), out_valid=1.
- a=4'b0101, b=4'b0100, c_in=0 → sum=4'b1001 (9), carry_out=0.
- a=4'b1011, b=4'b1001, c_in=0 → sum=4'b0100 (4), carry_out=1 (total 20).
- a=4'b1010, b=4'b0101, c_in=1 → sum=4'b0000, carry_out=1 (full carry ripple, total 16). Then set in_valid=0 for 2 cycles with changed operands → sum/carry_out hold 0/1 and out_valid=0.
- Exhaustive: all 512 combinations of a, b, c_in, issued back-to-back → each result matches a+b+c_in one cycle later, with out_valid continuously high.
